// File: rtl/call_stack.sv
// call_stack: hardware return-address stack for subroutine call/return.
// Each entry holds a return PC and the ALU flags saved at call time. A pop
// result is registered and presented for one cycle with out_valid, so the
// control unit can reload PC/flags in its following state.
module call_stack #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PC_WIDTH    = 9,
  parameter int unsigned FLAGS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_push_en,
  input  logic                     in_pop_en,
  input  logic [PC_WIDTH-1:0]      in_pc,
  input  logic [FLAGS_WIDTH-1:0]   in_flags,
  input  logic                     in_clear_errors,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [FLAGS_WIDTH-1:0]   out_flags,
  output logic                     out_valid,
  output logic                     out_empty,
  output logic                     out_full,
  output logic [$clog2(DEPTH):0]   out_depth,
  output logic                     out_overflow,
  output logic                     out_underflow
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SPW = AW + 1;
  localparam int unsigned EW  = PC_WIDTH + FLAGS_WIDTH;

  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  // Operation requested this cycle, decoded from the push/pop strobes.
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } op_e;

  op_e                    op;

  logic [EW-1:0]          mem_q [DEPTH];

  logic [SPW-1:0]         sp_q, sp_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [FLAGS_WIDTH-1:0] flags_q, flags_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;

  logic                   mem_we;
  logic [AW-1:0]          mem_waddr;
  logic [EW-1:0]          mem_wdata;

  logic                   empty;
  logic                   full;
  logic [AW-1:0]          wr_idx;
  logic [AW-1:0]          top_idx;
  logic [EW-1:0]          top_entry;
  logic [PC_WIDTH-1:0]    top_pc;
  logic [FLAGS_WIDTH-1:0] top_flags;

  assign empty     = (sp_q == '0);
  assign full      = (sp_q == SP_FULL);
  // When sp == DEPTH the low bits wrap to 0, so top_idx still lands on DEPTH-1.
  assign wr_idx    = sp_q[AW-1:0];
  assign top_idx   = sp_q[AW-1:0] - AW'(1);
  assign top_entry = mem_q[top_idx];
  assign top_pc    = top_entry[EW-1:FLAGS_WIDTH];
  assign top_flags = top_entry[FLAGS_WIDTH-1:0];

  // Decode the push/pop strobes into a single operation.
  always_comb begin
    op = OP_IDLE;
    case ({in_pop_en, in_push_en})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_SWAP;
      default: op = OP_IDLE;
    endcase
  end

  // Next-state, storage write and sticky error update for the selected operation.
  always_comb begin
    sp_d      = sp_q;
    pc_d      = pc_q;
    flags_d   = flags_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q & ~in_clear_errors;
    unf_d     = unf_q & ~in_clear_errors;
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    mem_wdata = {in_pc, in_flags};

    case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          mem_we = 1'b1;
          sp_d   = sp_q + SPW'(1);
        end
      end
      OP_POP: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          pc_d    = top_pc;
          flags_d = top_flags;
          sp_d    = sp_q - SPW'(1);
          valid_d = 1'b1;
        end
      end
      OP_SWAP: begin
        valid_d = 1'b1;
        if (empty) begin
          // Nothing stored: the new entry goes straight to the output.
          pc_d    = in_pc;
          flags_d = in_flags;
        end else begin
          // Old top is read out while the new entry replaces it in the same edge.
          pc_d      = top_pc;
          flags_d   = top_flags;
          mem_we    = 1'b1;
          mem_waddr = top_idx;
        end
      end
      default: ;
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q    <= '0;
      pc_q    <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage; contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign out_pc        = pc_q;
  assign out_flags     = flags_q;
  assign out_valid     = valid_q;
  assign out_empty     = empty;
  assign out_full      = full;
  assign out_depth     = sp_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack with hand-computed expectations.
module tb_call_stack;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_push_en = 1'b0;
  logic       in_pop_en = 1'b0;
  logic [8:0] in_pc = '0;
  logic [3:0] in_flags = '0;
  logic       in_clear_errors = 1'b0;
  logic [8:0] out_pc;
  logic [3:0] out_flags;
  logic       out_valid;
  logic       out_empty;
  logic       out_full;
  logic [4:0] out_depth;
  logic       out_overflow;
  logic       out_underflow;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  call_stack #(
    .DEPTH       (16),
    .PC_WIDTH    (9),
    .FLAGS_WIDTH (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_push_en      (in_push_en),
    .in_pop_en       (in_pop_en),
    .in_pc           (in_pc),
    .in_flags        (in_flags),
    .in_clear_errors (in_clear_errors),
    .out_pc          (out_pc),
    .out_flags       (out_flags),
    .out_valid       (out_valid),
    .out_empty       (out_empty),
    .out_full        (out_full),
    .out_depth       (out_depth),
    .out_overflow    (out_overflow),
    .out_underflow   (out_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic push, input logic pop, input logic [8:0] pc,
                       input logic [3:0] fl);
    in_push_en = push;
    in_pop_en  = pop;
    in_pc      = pc;
    in_flags   = fl;
    step();
    in_push_en = 1'b0;
    in_pop_en  = 1'b0;
  endtask

  initial begin
    // Reset and idle.
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("rst_empty", 32'(out_empty), 32'd1);
    chk("rst_full",  32'(out_full),  32'd0);
    chk("rst_depth", 32'(out_depth), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc",    32'(out_pc),    32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    chk("rst_ovf",   32'(out_overflow),  32'd0);
    chk("rst_unf",   32'(out_underflow), 32'd0);

    // Two pushes, two pops: LIFO order.
    drive(1'b1, 1'b0, 9'h1F0, 4'h9);
    chk("p1_depth", 32'(out_depth), 32'd1);
    drive(1'b1, 1'b0, 9'h0A3, 4'h5);
    chk("p2_depth", 32'(out_depth), 32'd2);
    chk("p2_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 1'b1, 9'h000, 4'h0);
    chk("pop1_pc",    32'(out_pc),    32'h0A3);
    chk("pop1_flags", 32'(out_flags), 32'h5);
    chk("pop1_valid", 32'(out_valid), 32'd1);
    chk("pop1_depth", 32'(out_depth), 32'd1);
    drive(1'b0, 1'b1, 9'h000, 4'h0);
    chk("pop2_pc",    32'(out_pc),    32'h1F0);
    chk("pop2_flags", 32'(out_flags), 32'h9);
    chk("pop2_valid", 32'(out_valid), 32'd1);
    chk("pop2_empty", 32'(out_empty), 32'd1);
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_pc",    32'(out_pc),    32'h1F0);

    // Fill, overflow, drain.
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 9'(i), 4'(i));
    chk("fill_full",  32'(out_full),  32'd1);
    chk("fill_depth", 32'(out_depth), 32'd16);
    chk("fill_ovf",   32'(out_overflow), 32'd0);
    drive(1'b1, 1'b0, 9'h1AB, 4'hE);
    chk("ovf_bit",   32'(out_overflow), 32'd1);
    chk("ovf_depth", 32'(out_depth),    32'd16);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 9'h000, 4'h0);
      chk($sformatf("drain%0d_pc", k),    32'(out_pc),    32'(15 - k));
      chk($sformatf("drain%0d_flags", k), 32'(out_flags), 32'((15 - k) & 15));
      chk($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
    end
    chk("drain_empty", 32'(out_empty), 32'd1);
    chk("drain_ovf_sticky", 32'(out_overflow), 32'd1);

    // Simultaneous push+pop, non-empty and empty.
    drive(1'b1, 1'b0, 9'h055, 4'h3);
    drive(1'b1, 1'b1, 9'h100, 4'hA);
    chk("swap_pc",    32'(out_pc),    32'h055);
    chk("swap_flags", 32'(out_flags), 32'h3);
    chk("swap_valid", 32'(out_valid), 32'd1);
    chk("swap_depth", 32'(out_depth), 32'd1);
    drive(1'b0, 1'b1, 9'h000, 4'h0);
    chk("swap_pop_pc",    32'(out_pc),    32'h100);
    chk("swap_pop_flags", 32'(out_flags), 32'hA);
    chk("swap_pop_depth", 32'(out_depth), 32'd0);
    drive(1'b1, 1'b1, 9'h077, 4'h1);
    chk("pass_pc",    32'(out_pc),    32'h077);
    chk("pass_flags", 32'(out_flags), 32'h1);
    chk("pass_valid", 32'(out_valid), 32'd1);
    chk("pass_depth", 32'(out_depth), 32'd0);
    chk("pass_unf",   32'(out_underflow), 32'd0);

    // Underflow, then clear racing an error, then plain clear.
    drive(1'b0, 1'b1, 9'h000, 4'h0);
    chk("unf_bit",   32'(out_underflow), 32'd1);
    chk("unf_valid", 32'(out_valid), 32'd0);
    chk("unf_pc",    32'(out_pc),    32'h077);
    chk("unf_flags", 32'(out_flags), 32'h1);
    in_clear_errors = 1'b1;
    drive(1'b0, 1'b1, 9'h000, 4'h0);
    chk("clr_race_unf", 32'(out_underflow), 32'd1);
    chk("clr_race_ovf", 32'(out_overflow),  32'd0);
    step();
    in_clear_errors = 1'b0;
    chk("clr_unf", 32'(out_underflow), 32'd0);
    chk("clr_ovf", 32'(out_overflow),  32'd0);

    // Push+pop while full: no overflow, top replaced.
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 9'(32'h100 + i), 4'(i));
    drive(1'b1, 1'b1, 9'h1CC, 4'h6);
    chk("fswap_pc",    32'(out_pc),    32'h10F);
    chk("fswap_flags", 32'(out_flags), 32'hF);
    chk("fswap_ovf",   32'(out_overflow), 32'd0);
    chk("fswap_depth", 32'(out_depth), 32'd16);
    drive(1'b0, 1'b1, 9'h000, 4'h0);
    chk("fswap_pop_pc",    32'(out_pc),    32'h1CC);
    chk("fswap_pop_flags", 32'(out_flags), 32'h6);
    chk("fswap_pop_depth", 32'(out_depth), 32'd15);

    // Asynchronous reset mid-cycle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 1'b0, 9'h011, 4'h1);
    drive(1'b1, 1'b0, 9'h022, 4'h2);
    drive(1'b1, 1'b0, 9'h033, 4'h3);
    drive(1'b0, 1'b1, 9'h000, 4'h0);
    chk("pre_ar_pc",    32'(out_pc),    32'h033);
    chk("pre_ar_depth", 32'(out_depth), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("ar_pc",    32'(out_pc),    32'd0);
    chk("ar_flags", 32'(out_flags), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_depth", 32'(out_depth), 32'd0);
    chk("ar_empty", 32'(out_empty), 32'd1);
    #1 reset = 1'b0;
    drive(1'b0, 1'b1, 9'h000, 4'h0);
    chk("ar_pop_unf",   32'(out_underflow), 32'd1);
    chk("ar_pop_valid", 32'(out_valid), 32'd0);
    chk("ar_pop_pc",    32'(out_pc),    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
